// File: rtl/fp_accum_seq.sv
// fp_accum_seq: sequences a stream of single-precision operands through an
// external adder, accumulating each group and emitting its sum and
// element count when the element flagged last has been added.
module fp_accum_seq #(
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        add_start,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  input  logic [31:0] add_sum,
  input  logic        add_done,
  output logic [31:0] acc_out,
  output logic        acc_valid,
  output logic [15:0] acc_count,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;

  localparam logic [6:0] WAIT_LAST = 7'(MAX_WAIT - 1);

  state_t      state, next;
  logic [31:0] acc;
  logic [31:0] operand;
  logic        last_flag;
  logic [15:0] count;
  logic [6:0]  wait_cnt;
  logic [31:0] out_hold;
  logic [15:0] count_hold;
  logic        capture;
  logic        timeout;

  // State register; reset forces IDLE, which also drops add_start at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next;
  end

  // Next-state decode and per-state control strobes.
  always_comb begin
    next      = state;
    in_ready  = 1'b0;
    add_start = 1'b0;
    acc_valid = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next = ISSUE;
      end
      ISSUE: begin
        add_start = 1'b1;
        if (add_done) begin
          capture = 1'b1;
          next    = last_flag ? EMIT : IDLE;
        end else begin
          next = WAIT;
        end
      end
      WAIT: begin
        if (add_done) begin
          capture = 1'b1;
          next    = last_flag ? EMIT : IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout = 1'b1;
          next    = last_flag ? EMIT : IDLE;
        end
      end
      EMIT: begin
        acc_valid = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  // Operand latch, accumulator, counters, sticky error and held results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc        <= '0;
      operand    <= '0;
      last_flag  <= 1'b0;
      count      <= '0;
      wait_cnt   <= '0;
      err        <= 1'b0;
      out_hold   <= '0;
      count_hold <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        operand   <= in_data;
        last_flag <= in_last;
      end
      if (capture) begin
        acc <= add_sum;
        if (count != '1) count <= count + 16'd1;
      end
      if (timeout) err <= 1'b1;
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 7'd1;
      if (state == EMIT) begin
        out_hold   <= acc;
        count_hold <= count;
        acc        <= '0;
        count      <= '0;
      end
    end
  end

  assign add_a = acc;
  assign add_b = operand;
  // During EMIT the live accumulator is shown; afterwards the copy taken on
  // leaving EMIT holds the result until the next group is emitted.
  assign acc_out   = acc_valid ? acc   : out_hold;
  assign acc_count = acc_valid ? count : count_hold;

endmodule

// File: tb/tb_fp_accum_seq.sv
// Directed bench for fp_accum_seq; the bench plays the adder with
// hand-computed sums and fixed latencies.
module tb_fp_accum_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic        add_start;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic        add_done;
  logic [31:0] acc_out;
  logic        acc_valid;
  logic [15:0] acc_count;
  logic        err;

  int compared   = 0;
  int mismatched = 0;

  fp_accum_seq #(.MAX_WAIT(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .add_start (add_start),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_sum   (add_sum),
    .add_done  (add_done),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .acc_count (acc_count),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. lat = 0: add_done in the ISSUE
  // cycle; lat > 0: add_done after lat WAIT cycles; lat < 0: never answer.
  // Returns at the negedge after capture (or timeout).
  task automatic do_elem(input logic [31:0] data, input logic last,
                         input logic [31:0] exp_a, input logic [31:0] sum,
                         input int lat, input logic hold);
    int n;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    check("issue_start", {31'd0, add_start}, 32'd1);
    check("issue_a", add_a, exp_a);
    check("issue_b", add_b, data);
    check("issue_ready", {31'd0, in_ready}, 32'd0);
    n = (lat < 0) ? 64 : lat;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("wait_start", {31'd0, add_start}, 32'd0);
      check("wait_a", add_a, exp_a);
      check("wait_ready", {31'd0, in_ready}, 32'd0);
    end
    if (lat < 0) begin
      check("pre_timeout_err", {31'd0, err}, 32'd0);
      @(negedge clk);
    end else begin
      add_done = 1'b1;
      add_sum  = sum;
      @(negedge clk);
      add_done = 1'b0;
      add_sum  = 32'hDEADBEEF;
    end
  endtask

  // Called at the negedge where EMIT should be showing.
  task automatic check_emit(input string tag, input logic [31:0] sum, input logic [15:0] cnt);
    check({tag, "_valid"}, {31'd0, acc_valid}, 32'd1);
    check({tag, "_out"}, acc_out, sum);
    check({tag, "_count"}, {16'd0, acc_count}, {16'd0, cnt});
    @(negedge clk);
    check({tag, "_valid_drop"}, {31'd0, acc_valid}, 32'd0);
    check({tag, "_out_hold"}, acc_out, sum);
    check({tag, "_count_hold"}, {16'd0, acc_count}, {16'd0, cnt});
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    add_sum  = 32'hDEADBEEF;
    add_done = 1'b0;
    #3;
    check("rst_start", {31'd0, add_start}, 32'd0);
    check("rst_valid", {31'd0, acc_valid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_out", acc_out, 32'd0);
    check("rst_count", {16'd0, acc_count}, 32'd0);
    check("rst_a", add_a, 32'd0);
    check("rst_b", add_b, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0 + 3.0 with a 3-cycle adder
    do_elem(32'h3F800000, 1'b0, 32'h00000000, 32'h3F800000, 3, 1'b0);
    do_elem(32'h40000000, 1'b0, 32'h3F800000, 32'h40400000, 3, 1'b0);
    do_elem(32'h40400000, 1'b1, 32'h40400000, 32'h40C00000, 3, 1'b0);
    check_emit("grp3", 32'h40C00000, 16'd3);

    // add_done while idle must not touch the accumulator
    add_done = 1'b1;
    add_sum  = 32'h12345678;
    @(negedge clk);
    add_done = 1'b0;
    add_sum  = 32'hDEADBEEF;
    check("idle_done_acc", add_a, 32'h00000000);
    check("idle_done_valid", {31'd0, acc_valid}, 32'd0);

    // single element, adder answers in the ISSUE cycle: EMIT right after
    do_elem(32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 0, 1'b0);
    check_emit("single", 32'h00000000, 16'd1);

    // in_valid held for the whole group: 1.0 + 3.0 = 4.0, two elements
    do_elem(32'h3F800000, 1'b0, 32'h00000000, 32'h3F800000, 2, 1'b1);
    do_elem(32'h40400000, 1'b1, 32'h3F800000, 32'h40800000, 2, 1'b1);
    check("hold_emit_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    check_emit("hold", 32'h40800000, 16'd2);

    // second element times out: result keeps the first sum, count 1
    do_elem(32'h3F800000, 1'b0, 32'h00000000, 32'h3F800000, 1, 1'b0);
    do_elem(32'h40000000, 1'b1, 32'h3F800000, 32'h00000000, -1, 1'b0);
    check("timeout_err", {31'd0, err}, 32'd1);
    check_emit("tmo", 32'h3F800000, 16'd1);
    do_elem(32'h40000000, 1'b1, 32'h00000000, 32'h40000000, 1, 1'b0);
    check_emit("after_tmo", 32'h40000000, 16'd1);
    check("err_sticky", {31'd0, err}, 32'd1);

    // reset in ISSUE drops add_start without a clock edge
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_start", {31'd0, add_start}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_issue_start", {31'd0, add_start}, 32'd0);
    check("rst_issue_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // reset in WAIT of the second element, then a fresh group
    do_elem(32'h3F800000, 1'b0, 32'h00000000, 32'h3F800000, 1, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h40000000;
    in_last  = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_wait_a", add_a, 32'h3F800000);
    #2;
    reset = 1'b0;
    #1;
    check("rst_wait_start", {31'd0, add_start}, 32'd0);
    check("rst_wait_acc", add_a, 32'h00000000);
    check("rst_wait_b", add_b, 32'h00000000);
    check("rst_wait_out", acc_out, 32'h00000000);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    do_elem(32'h40000000, 1'b1, 32'h00000000, 32'h40000000, 1, 1'b0);
    check_emit("fresh", 32'h40000000, 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fp_accum_seq.md
FP_ACCUM_SEQ -- requirements
Module: fp_accum_seq

Interface
REQ-001 Parameter MAX_WAIT, default 64: cycles in WAIT without add_done before the element is abandoned.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-low reset; low clears all state immediately, regardless of clk.
REQ-004 Port in_valid, input, 1: upstream offers in_data.
REQ-005 Port in_data, input, 32: IEEE-754 single-precision operand.
REQ-006 Port in_last, input, 1: marks in_data as the final element of a group.
REQ-007 Port in_ready, output, 1: block accepts an element this cycle.
REQ-008 Port add_start, output, 1: one-cycle request to the adder.
REQ-009 Port add_a, output, 32: adder operand a (running accumulator).
REQ-010 Port add_b, output, 32: adder operand b (latched element).
REQ-011 Port add_sum, input, 32: adder result.
REQ-012 Port add_done, input, 1: adder result valid; may assert in the same cycle as add_start.
REQ-013 Port acc_out, output, 32: completed group sum.
REQ-014 Port acc_valid, output, 1: one-cycle pulse, acc_out/acc_count valid.
REQ-015 Port acc_count, output, 16: number of elements in the emitted group.
REQ-016 Port err, output, 1: sticky adder-timeout flag.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, EMIT; the reset state is IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; an element is accepted on a clk edge with in_valid & in_ready.
REQ-019 On acceptance, in_data SHALL be latched into an operand register and in_last into a last flag; the FSM SHALL go to ISSUE.
REQ-020 In ISSUE, add_start SHALL be 1 for exactly that cycle; add_a = accumulator, add_b = latched operand.
REQ-021 add_a and add_b SHALL stay stable from ISSUE until the cycle add_done is sampled or a timeout occurs.
REQ-022 If add_done = 1 during ISSUE, add_sum SHALL be captured at that edge and WAIT skipped.
REQ-023 Otherwise ISSUE -> WAIT; in WAIT, add_done = 1 SHALL capture add_sum into the accumulator.
REQ-024 After capture: last flag set -> EMIT, else -> IDLE.
REQ-025 The element counter SHALL increment by 1 on each capture and saturate at 16'hFFFF.
REQ-026 A 7-bit wait counter SHALL clear on entering WAIT and increment each WAIT cycle.
REQ-027 At wait count MAX_WAIT-1 without add_done, the block SHALL set err, leave the accumulator and count unchanged, and then follow the REQ-024 transitions.
REQ-028 err SHALL remain 1 until reset.
REQ-029 EMIT SHALL last one cycle: acc_valid = 1, acc_out = accumulator, acc_count = counter.
REQ-030 Leaving EMIT, the accumulator SHALL become 32'h00000000 and the counter 0; the FSM SHALL go to IDLE.
REQ-031 acc_out and acc_count SHALL hold their last emitted values until the next EMIT.
REQ-032 add_done outside ISSUE/WAIT SHALL be ignored.
REQ-033 No floating-point arithmetic SHALL be done in this block; sums come only from add_sum.
REQ-034 A single-element group (in_last on the first element) SHALL emit 0.0 + element as returned by the adder.

Reset
REQ-035 While reset = 0, the block SHALL hold: state IDLE; accumulator, counter and wait counter 0; add_start, acc_valid and err 0; acc_out, acc_count, add_a and add_b 0.
REQ-036 Reset asserted mid-ISSUE or mid-WAIT SHALL drop add_start to 0 asynchronously and discard the in-flight element.
REQ-037 After reset deasserts, in_ready SHALL be 1 on the first clk edge.

Verification
REQ-038 Stream 3F800000, 40000000, 40400000 (last on third), adder model with 3-cycle latency -> one acc_valid pulse, acc_out = 40C00000, acc_count = 3.
REQ-039 Single element 00000000 with in_last, adder returns add_done in the ISSUE cycle -> no WAIT visit, acc_out = 00000000, acc_count = 1, EMIT two cycles after acceptance.
REQ-040 in_valid held high for the whole group -> in_ready low during ISSUE/WAIT/EMIT, each element accepted exactly once, none duplicated.
REQ-041 Adder never asserts add_done, MAX_WAIT = 64 -> err = 1 after 64 WAIT cycles, FSM returns to IDLE, later groups still sum correctly with err still 1.
REQ-042 Reset pulled low in WAIT of the second element of 3F800000, 40000000 -> add_start = 0 and accumulator = 0 at once; a fresh group 40000000 (last) then yields 40000000, count 1.
